dmem_arbiter: RTL and testbench

- Arbitrates the single-port board/data RAM between two requesters:
  - the CPU load/store port (LB/SB traffic), which may read and write;
  - the display tile scanner, which only reads board cells.
- The CPU has priority. A bounded-wait counter guarantees the scanner a slot after MAX_WAIT consecutive denied cycles.
- Sits between the CPU datapath, the VGA/tile fetch logic and the RAM macro (1-cycle synchronous read).

---
 rtl/dmem_arbiter.sv | 110 +++++++++++
 tb/tb_dmem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Shared board/data RAM arbiter: CPU load/store port vs. display tile scanner.
// CPU has priority; a saturating wait counter forces a scanner slot after MAX_WAIT denials.
module dmem_arbiter #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int MAX_WAIT = 3,
  parameter int WAIT_W   = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              C_REQ,
  input  logic              C_WE,
  input  logic [ADDR_W-1:0] C_ADDR,
  input  logic [DATA_W-1:0] C_WDATA,
  output logic              C_GNT,
  output logic              C_RVALID,
  output logic [DATA_W-1:0] C_RDATA,
  input  logic              D_REQ,
  input  logic [ADDR_W-1:0] D_ADDR,
  output logic              D_GNT,
  output logic              D_RVALID,
  output logic [DATA_W-1:0] D_RDATA,
  output logic              M_EN,
  output logic              M_WE,
  output logic [ADDR_W-1:0] M_ADDR,
  output logic [DATA_W-1:0] M_WDATA,
  input  logic [DATA_W-1:0] M_RDATA,
  output logic              D_STARVED
);

  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DISP} owner_t;

  localparam logic [WAIT_W-1:0] MAX_CNT = WAIT_W'(MAX_WAIT);

  owner_t            rd_owner_reg, rd_owner_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic [DATA_W-1:0] c_rdata_reg, d_rdata_reg;
  logic              starved;
  logic              c_gnt, d_gnt;

  assign starved = (wait_cnt_reg == MAX_CNT);

  // Grants are forced low while reset is held so nothing reaches the RAM.
  always_comb begin
    c_gnt = 1'b0;
    d_gnt = 1'b0;
    if (RESET) begin
      if (D_REQ && (!C_REQ || starved)) begin
        d_gnt = 1'b1;
      end else if (C_REQ) begin
        c_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    M_EN    = c_gnt | d_gnt;
    M_WE    = c_gnt & C_WE;
    M_ADDR  = '0;
    M_WDATA = '0;
    if (c_gnt) begin
      M_ADDR  = C_ADDR;
      M_WDATA = C_WDATA;
    end else if (d_gnt) begin
      M_ADDR  = D_ADDR;
    end
  end

  always_comb begin
    rd_owner_next = OWN_NONE;
    if (c_gnt && !C_WE) begin
      rd_owner_next = OWN_CPU;
    end else if (d_gnt) begin
      rd_owner_next = OWN_DISP;
    end

    wait_cnt_next = '0;
    if (D_REQ && !d_gnt) begin
      wait_cnt_next = starved ? wait_cnt_reg : wait_cnt_reg + WAIT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rd_owner_reg <= OWN_NONE;
      wait_cnt_reg <= '0;
      c_rdata_reg  <= '0;
      d_rdata_reg  <= '0;
    end else begin
      rd_owner_reg <= rd_owner_next;
      wait_cnt_reg <= wait_cnt_next;
      if (rd_owner_reg == OWN_CPU) begin
        c_rdata_reg <= M_RDATA;
      end
      if (rd_owner_reg == OWN_DISP) begin
        d_rdata_reg <= M_RDATA;
      end
    end
  end

  // Return data is forwarded from the RAM in the valid cycle, then held.
  assign C_GNT     = c_gnt;
  assign D_GNT     = d_gnt;
  assign C_RVALID  = (rd_owner_reg == OWN_CPU);
  assign D_RVALID  = (rd_owner_reg == OWN_DISP);
  assign C_RDATA   = C_RVALID ? M_RDATA : c_rdata_reg;
  assign D_RDATA   = D_RVALID ? M_RDATA : d_rdata_reg;
  assign D_STARVED = RESET & starved;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: two instances (MAX_WAIT=3 and MAX_WAIT=0) share one stimulus,
// each with its own RAM and a behavioural model checked every cycle.
module tb_dmem_arbiter;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       c_req = 1'b0, c_we = 1'b0, d_req = 1'b0;
  logic [7:0] c_addr = '0, c_wdata = '0, d_addr = '0;

  logic       c_gnt [2], c_rvalid [2], d_gnt [2], d_rvalid [2];
  logic       m_en [2], m_we [2], d_starved [2];
  logic [7:0] c_rdata [2], d_rdata [2], m_addr [2], m_wdata [2];
  logic [7:0] m_rdata [2];
  logic [7:0] ram [2][256];

  int vec_cnt = 0;
  int miss_cnt = 0;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(3), .WAIT_W(2)) u_dut (
    .CLK(CLK), .RESET(RESET),
    .C_REQ(c_req), .C_WE(c_we), .C_ADDR(c_addr), .C_WDATA(c_wdata),
    .C_GNT(c_gnt[0]), .C_RVALID(c_rvalid[0]), .C_RDATA(c_rdata[0]),
    .D_REQ(d_req), .D_ADDR(d_addr),
    .D_GNT(d_gnt[0]), .D_RVALID(d_rvalid[0]), .D_RDATA(d_rdata[0]),
    .M_EN(m_en[0]), .M_WE(m_we[0]), .M_ADDR(m_addr[0]), .M_WDATA(m_wdata[0]),
    .M_RDATA(m_rdata[0]), .D_STARVED(d_starved[0])
  );

  dmem_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_WAIT(0), .WAIT_W(1)) u_dut0 (
    .CLK(CLK), .RESET(RESET),
    .C_REQ(c_req), .C_WE(c_we), .C_ADDR(c_addr), .C_WDATA(c_wdata),
    .C_GNT(c_gnt[1]), .C_RVALID(c_rvalid[1]), .C_RDATA(c_rdata[1]),
    .D_REQ(d_req), .D_ADDR(d_addr),
    .D_GNT(d_gnt[1]), .D_RVALID(d_rvalid[1]), .D_RDATA(d_rdata[1]),
    .M_EN(m_en[1]), .M_WE(m_we[1]), .M_ADDR(m_addr[1]), .M_WDATA(m_wdata[1]),
    .M_RDATA(m_rdata[1]), .D_STARVED(d_starved[1])
  );

  // RAM macros, 1-cycle synchronous read
  always @(posedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (m_en[k]) begin
        if (m_we[k]) ram[k][m_addr[k]] <= m_wdata[k];
        else         m_rdata[k] <= ram[k][m_addr[k]];
      end
    end
  end

  task automatic chk(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL t=%0t dut%0d %s: got %0h expected %0h", $time, k, name, act, exp);
    end
  endtask

  // Behavioural model state
  int         maxw [2] = '{3, 0};
  int         streak [2];
  bit         pc [2], pd [2];
  logic [7:0] pdata [2], lc [2], ld [2];
  logic [7:0] mem_m [2][256];

  logic       e_cg, e_dg, e_en, e_we, e_crv, e_drv, e_st;
  logic [7:0] e_addr, e_wd, e_crd, e_drd;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_rdata[k] = '0;
      streak[k] = 0; pc[k] = 0; pd[k] = 0;
      pdata[k] = '0; lc[k] = '0; ld[k] = '0;
      for (int i = 0; i < 256; i++) begin
        ram[k][i]   = 8'(i) ^ 8'hA5;
        mem_m[k][i] = 8'(i) ^ 8'hA5;
      end
      ram[k][8'h3E]   = 8'h20;
      mem_m[k][8'h3E] = 8'h20;
    end
  end

  // Per-cycle compare against the model
  initial begin
    forever begin
      @(negedge CLK);
      for (int k = 0; k < 2; k++) begin
        if (!RESET) begin
          e_cg = 0; e_dg = 0; e_en = 0; e_we = 0; e_addr = 0; e_wd = 0;
          e_crv = 0; e_crd = 0; e_drv = 0; e_drd = 0; e_st = 0;
          streak[k] = 0; pc[k] = 0; pd[k] = 0; lc[k] = 0; ld[k] = 0;
        end else begin
          e_dg   = d_req && (!c_req || streak[k] >= maxw[k]);
          e_cg   = c_req && !e_dg;
          e_en   = e_cg || e_dg;
          e_we   = e_cg && c_we;
          e_addr = e_cg ? c_addr : (e_dg ? d_addr : 8'h00);
          e_wd   = e_cg ? c_wdata : 8'h00;
          e_crv  = pc[k];
          e_crd  = pc[k] ? pdata[k] : lc[k];
          e_drv  = pd[k];
          e_drd  = pd[k] ? pdata[k] : ld[k];
          e_st   = (streak[k] == maxw[k]);
        end
        chk(k, "C_GNT", c_gnt[k], e_cg);
        chk(k, "D_GNT", d_gnt[k], e_dg);
        chk(k, "M_EN", m_en[k], e_en);
        chk(k, "M_WE", m_we[k], e_we);
        chk(k, "M_ADDR", m_addr[k], e_addr);
        chk(k, "M_WDATA", m_wdata[k], e_wd);
        chk(k, "C_RVALID", c_rvalid[k], e_crv);
        chk(k, "C_RDATA", c_rdata[k], e_crd);
        chk(k, "D_RVALID", d_rvalid[k], e_drv);
        chk(k, "D_RDATA", d_rdata[k], e_drd);
        chk(k, "D_STARVED", d_starved[k], e_st);
        if (RESET) begin
          if (pc[k]) lc[k] = pdata[k];
          if (pd[k]) ld[k] = pdata[k];
          pc[k] = e_cg && !c_we;
          pd[k] = e_dg;
          if (e_cg && !c_we) pdata[k] = mem_m[k][c_addr];
          else if (e_dg)     pdata[k] = mem_m[k][d_addr];
          if (e_we) mem_m[k][c_addr] = c_wdata;
          if (d_req && !e_dg) streak[k] = (streak[k] < maxw[k]) ? streak[k] + 1 : streak[k];
          else                streak[k] = 0;
        end
      end
    end
  end

  task automatic adv;
    @(posedge CLK);
    #1;
  endtask

  logic [7:0] t4_exp [3] = '{8'hE5, 8'hE4, 8'hE7};

  // Directed stimulus with hand-computed literal expectations
  initial begin
    #1 RESET = 1'b0;
    repeat (2) @(negedge CLK);
    adv;
    RESET = 1'b1;

    // CPU read of 0x3E
    c_req = 1; c_we = 0; c_addr = 8'h3E;
    @(negedge CLK);
    chk(0, "t1 C_GNT", c_gnt[0], 1);
    chk(0, "t1 M_ADDR", m_addr[0], 8'h3E);
    adv; c_req = 0;
    @(negedge CLK);
    chk(0, "t1 C_RVALID", c_rvalid[0], 1);
    chk(0, "t1 C_RDATA", c_rdata[0], 8'h20);

    // CPU write then read-back of 0xF7
    adv; c_req = 1; c_we = 1; c_addr = 8'hF7; c_wdata = 8'h0F;
    @(negedge CLK);
    chk(0, "t2 M_WE", m_we[0], 1);
    chk(0, "t2 M_WDATA", m_wdata[0], 8'h0F);
    adv; c_we = 0;
    @(negedge CLK);
    chk(0, "t2 write C_RVALID", c_rvalid[0], 0);
    adv; c_req = 0;
    @(negedge CLK);
    chk(0, "t2 C_RVALID", c_rvalid[0], 1);
    chk(0, "t2 C_RDATA", c_rdata[0], 8'h0F);

    // Both requesting continuously
    adv; c_req = 1; c_we = 0; c_addr = 8'h10; d_req = 1; d_addr = 8'h20;
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      chk(0, "t3 D_GNT", d_gnt[0], (i % 4) == 3);
      chk(0, "t3 C_GNT", c_gnt[0], (i % 4) != 3);
      chk(0, "t3 D_STARVED", d_starved[0], (i % 4) == 3);
      chk(1, "t3 D_GNT", d_gnt[1], 1);
      chk(1, "t3 C_GNT", c_gnt[1], 0);
      adv;
    end
    d_req = 0;
    @(negedge CLK);
    chk(1, "t3 C_GNT on drop", c_gnt[1], 1);

    // Scanner streaming 0x40..0x42
    adv; c_req = 0;
    for (int i = 0; i < 5; i++) begin
      d_req  = (i < 3);
      d_addr = 8'h40 + 8'(i);
      @(negedge CLK);
      if (i < 3) chk(0, "t4 D_GNT", d_gnt[0], 1);
      if (i >= 1 && i <= 3) begin
        chk(0, "t4 D_RVALID", d_rvalid[0], 1);
        chk(0, "t4 D_RDATA", d_rdata[0], t4_exp[i-1]);
      end
      if (i == 4) chk(0, "t4 D_RVALID end", d_rvalid[0], 0);
      adv;
    end

    // Reset while a CPU read is in flight
    d_req = 0; c_req = 1; c_we = 0; c_addr = 8'h55;
    @(negedge CLK);
    chk(0, "t5 C_GNT", c_gnt[0], 1);
    #2 RESET = 1'b0;
    @(negedge CLK);
    chk(0, "t5 rst C_GNT", c_gnt[0], 0);
    chk(0, "t5 rst M_EN", m_en[0], 0);
    chk(0, "t5 rst C_RVALID", c_rvalid[0], 0);
    adv; RESET = 1'b1; c_req = 0;
    @(negedge CLK);
    chk(0, "t5 post C_RVALID", c_rvalid[0], 0);
    chk(0, "t5 post C_RDATA", c_rdata[0], 0);

    // Mixed traffic: drops, shared addresses, writes racing scanner reads
    adv;
    for (int i = 0; i < 30; i++) begin
      c_req   = (i % 3) != 0;
      c_we    = (i % 4) == 1;
      c_addr  = 8'hF0 + 8'(i % 4);
      c_wdata = 8'(i * 13);
      d_req   = (i % 5) != 2;
      d_addr  = (i % 2 == 1) ? c_addr : 8'h40 + 8'(i);
      @(negedge CLK);
      adv;
    end
    c_req = 0; d_req = 0;
    repeat (3) adv;
    @(negedge CLK);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
